imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, XLEN-parametrised immediate generator for the decode stage.
//  Sits between fetch/decode and the ALU operand mux. Extracts and extends I/S/B/J/U/shamt
//  immediates from a 32-bit instruction.
//  Carries a sideband tag through a valid/ready stage with a 2-entry skid buffer.
//  Counts illegal immediate selects.
// PARAMETERS
//  XLEN   32  datapath width; legal values 32 or 64
//  TAG_W  5   width of the passthrough tag (rd/ROB id)
//  CNT_W  8   width of the saturating illegal-select counter
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       upstream instruction valid
//  in_ready   out  1       stage can accept (= !skid_valid)
//  in_instr   in   32      raw instruction word
//  in_sel     in   3       imm_sel_e: 0 I, 1 S, 2 B, 3 J, 4 U, 5 SHAMT, 6 ZIMM, 7 reserved
//  in_tag     in   TAG_W   sideband, passed unchanged
//  out_valid  out  1       immediate valid
//  out_ready  in   1       downstream accepts
//  out_imm    out  XLEN    extended immediate
//  out_tag    out  TAG_W   tag of out_imm
//  out_illegal out 1       in_sel was illegal; out_imm is 0
//  clear_cnt  in   1       synchronous clear of err_count
//  err_count  out  CNT_W   saturating count of accepted illegal selects
// BEHAVIOUR
//  - Reset values: out_valid 0, out_imm 0, out_tag 0, out_illegal 0, err_count 0.
//    Skid buffer is empty at reset, so in_ready is 1.
//  - Accept happens when in_valid && in_ready. Emit happens when out_valid && out_ready.
//  - Latency: the immediate is computed at accept and registered.
//    out_valid rises 1 cycle after accept when the output register is empty or draining.
//  - Throughput is 1/cycle. FIFO order is preserved.
//  - Skid buffer: if the output register is held (out_valid && !out_ready), the accepted
//    beat goes to the skid register and in_ready drops on the next cycle.
//    When the output drains, the skid entry moves to the output and in_ready returns to 1.
//  - Output is held stable while out_valid && !out_ready.
//  - Extension rules (all extend to XLEN):
//    I: sext(instr[31:20])
//    S: sext({instr[31:25], instr[11:7]})
//    B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
//    J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
//    U: sext({instr[31:12], 12'h0}); on XLEN=64, bits 63:32 copy instr[31]
//    SHAMT: zext(instr[24:20]) for XLEN=32; zext(instr[25:20]) for XLEN=64
//  - Illegal sel: out_imm is 0 and out_illegal is 1. The beat still flows normally.
//  - err_count increments on each accepted illegal beat and saturates at all-ones.
//    If clear_cnt and an illegal accept occur in the same cycle, err_count becomes 1.
//  - Reset mid-operation: both entries are dropped immediately and asynchronously.
// CONFIGURATION
//  - IMM_GEN_ZIMM_EN defined: sel 6 yields zext(instr[19:15]) (CSR zimm) and is legal.
//  - IMM_GEN_ZIMM_EN undefined: sel 6 is illegal and behaves like sel 7.
// STRUCTURE
//  - imm_gen_pkg holds: the imm_sel_e enum (3 bits), the IMM_SEL_* constants, and
//    function sext_to_xlen.
//  - Sub-module imm_extract: purely combinational, parameterised by XLEN.
//    Maps (instr, sel) to (imm, illegal).
//  - imm_gen_pipe instantiates imm_extract once, on the input side, and holds the
//    output register, the skid register and the counter.
// TESTING
//  - XLEN=32, sel I, instr 0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF,
//    out_valid=1.
//  - sel B, instr 0xFE000EE3 -> out_imm 0xFFFFFFFC.
//  - sel U, instr 0x123450B7 -> out_imm 0x12345000.
//  - XLEN=64, sel U, instr 0x800000B7 -> 0xFFFFFFFF80000000.
//  - XLEN=64, sel SHAMT, instr 0x03F0D093 -> 0x3F.
//  - Backpressure: out_ready=0, push tags 1,2,3 on back-to-back cycles.
//    Expect: tags 1,2 accepted; in_ready=0 from the cycle after tag 2 is accepted;
//    tag 3 held upstream. Then out_ready=1 -> tags 1,2,3 emerge in order, with no loss or
//    duplication.
//  - CNT_W=2: five accepted sel=7 beats -> err_count=3 (saturated), each with
//    out_illegal=1 and out_imm=0.
//    Then clear_cnt with a simultaneous illegal beat -> err_count=1.
//  - Build with IMM_GEN_ZIMM_EN: sel 6, instr 0x000FD073 -> out_imm 0x1F, out_illegal=0.
//    Without the macro: out_imm 0, out_illegal=1.
//  - Assert rst_n low while both entries are full -> out_valid=0 and in_ready=1
//    immediately. No stale beat appears after reset release.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and helpers for the immediate generator.
// The select encoding is shared by the decode stage and imm_extract.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_SEL_I     = 3'd0,
        IMM_SEL_S     = 3'd1,
        IMM_SEL_B     = 3'd2,
        IMM_SEL_J     = 3'd3,
        IMM_SEL_U     = 3'd4,
        IMM_SEL_SHAMT = 3'd5,
        IMM_SEL_ZIMM  = 3'd6,
        IMM_SEL_RSVD  = 3'd7
    } imm_sel_e;

    localparam int IMM_MAX_XLEN = 64;

    // Sign-extends the low w bits of v (1 <= w <= 32) to 64 bits; callers truncate to XLEN.
    function automatic logic [63:0] sext_to_xlen(input logic [31:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = $signed({32'h0, v} << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: maps (instr, sel) to an XLEN immediate and an illegal flag.
// IMM_GEN_ZIMM_EN makes select 6 a legal CSR zimm; otherwise it is treated as reserved.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [IMM_MAX_XLEN-1:0] wide;
    logic                    unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        wide    = '0;
        illegal = 1'b0;
        case (imm_sel_e'(sel))
            IMM_SEL_I:     wide = sext_to_xlen({20'h0, instr[31:20]}, 12);
            IMM_SEL_S:     wide = sext_to_xlen({20'h0, instr[31:25], instr[11:7]}, 12);
            IMM_SEL_B:     wide = sext_to_xlen({19'h0, instr[31], instr[7], instr[30:25],
                                                instr[11:8], 1'b0}, 13);
            IMM_SEL_J:     wide = sext_to_xlen({11'h0, instr[31], instr[19:12], instr[20],
                                                instr[30:21], 1'b0}, 21);
            IMM_SEL_U:     wide = sext_to_xlen({instr[31:12], 12'h0}, 32);
            // RV64 shift amounts carry one extra bit
            IMM_SEL_SHAMT: wide = (XLEN == 64) ? {58'h0, instr[25:20]} : {59'h0, instr[24:20]};
`ifdef IMM_GEN_ZIMM_EN
            IMM_SEL_ZIMM:  wide = {59'h0, instr[19:15]};
`endif
            default:       illegal = 1'b1;
        endcase
    end

    assign imm = wide[XLEN-1:0];

    generate
        if (XLEN < IMM_MAX_XLEN) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^wide[IMM_MAX_XLEN-1:XLEN];
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extraction at accept, one output register plus one skid entry.
// Optional CSR zimm support is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [XLEN-1:0]  imm_p0;
    logic             ill_p0;
    logic             vld_p1;
    logic [XLEN-1:0]  imm_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             ill_p1;
    logic             skid_vld;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;
    logic             accept;
    logic             out_free;
    logic [CNT_W-1:0] cnt_q;

    // Stage p0: combinational extraction on the accepted beat
    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .sel     (in_sel),
        .imm     (imm_p0),
        .illegal (ill_p0)
    );

    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign out_free = !vld_p1 || out_ready;

    // Stage p1: output register, refilled from skid first to keep FIFO order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            tag_p1 <= '0;
            ill_p1 <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                vld_p1 <= 1'b1;
                imm_p1 <= skid_imm;
                tag_p1 <= skid_tag;
                ill_p1 <= skid_ill;
            end else if (accept) begin
                vld_p1 <= 1'b1;
                imm_p1 <= imm_p0;
                tag_p1 <= in_tag;
                ill_p1 <= ill_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Skid entry: catches the beat accepted while the output register is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld <= 1'b0;
        end else if (out_free) begin
            skid_vld <= 1'b0;
        end else if (accept) begin
            skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !out_free) begin
            skid_imm <= imm_p0;
            skid_tag <= in_tag;
            skid_ill <= ill_p0;
        end
    end

    // A clear that coincides with an illegal accept still counts that beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_cnt) begin
            cnt_q <= (accept && ill_p0) ? CNT_W'(1) : '0;
        end else if (accept && ill_p0) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign out_valid   = vld_p1;
    assign out_imm     = imm_p1;
    assign out_tag     = tag_p1;
    assign out_illegal = ill_p1;
    assign err_count   = cnt_q;

endmodule
